// File: rtl/dac_feeder_pkg.sv
// Shared types for the DAC sample feeder.
// Sample layout matches the QPSK modulator output bus.
package dac_feeder_pkg;

  localparam int IQ_W = 16;
  localparam logic [15:0] UNDERFLOW_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  typedef struct packed {
    logic [IQ_W-1:0] i;
    logic [IQ_W-1:0] q;
  } iq_sample_t;

endpackage

// File: rtl/dac_sample_feeder_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Level is a separate counter so full and empty never alias.
module sync_fifo_fwft #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  assign do_rd = rd_en && !empty && !flush;
  assign do_wr = wr_en && (!full || do_rd) && !flush;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/dac_sample_feeder.sv
// Buffers bursty modulator samples and paces them out to the DAC
// at one sample per DIVIDER clocks, with prefill and status tracking.
module dac_sample_feeder
  import dac_feeder_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int PREFILL  = 32,
  parameter int DIVIDER  = 4,
  parameter int SAMPLE_W = IQ_W
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic [2*SAMPLE_W-1:0]    i_data,
  input  logic                     i_valid,
  output logic [SAMPLE_W-1:0]      o_dac_i,
  output logic [SAMPLE_W-1:0]      o_dac_q,
  output logic                     o_dac_valid,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [1:0]               o_state,
  output logic                     o_overflow,
  output logic [15:0]              o_underflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DIVIDER);
  localparam int DW = 2 * SAMPLE_W;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIVIDER - 1);
  localparam logic [LW-1:0] PRE_LVL = LW'(PREFILL);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic            tick;
  logic [DW-1:0]   head;
  logic [LW-1:0]   level;
  logic            full;
  logic            empty;
  logic            flush;
  logic            pop;
  logic            push;
  logic            drop;
  logic            underflow;
  logic            zero_out;

  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge i_clk) begin
    if (i_reset)   cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!i_enable) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:    state_nxt = ST_PREFILL;
        ST_PREFILL: if (level >= PRE_LVL) state_nxt = ST_RUN;
        ST_RUN:     if (tick && empty) state_nxt = ST_PREFILL;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // Disable outranks underflow, which outranks a normal pop.
  always_comb begin
    flush     = 1'b0;
    pop       = 1'b0;
    underflow = 1'b0;
    zero_out  = 1'b0;
    unique case (1'b1)
      (!i_enable || state == ST_IDLE): begin
        flush    = 1'b1;
        zero_out = 1'b1;
      end
      (i_enable && state == ST_RUN && tick): begin
        pop       = !empty;
        underflow = empty;
        zero_out  = empty;
      end
      default: ;
    endcase
  end

  assign push = i_valid && !flush && (!full || pop);
  assign drop = i_valid && !flush && full && !pop;

  sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk     (i_clk),
    .reset   (i_reset),
    .flush   (flush),
    .wr_en   (push),
    .wr_data (i_data),
    .rd_en   (pop),
    .rd_data (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_dac_i         <= '0;
      o_dac_q         <= '0;
      o_dac_valid     <= 1'b0;
      o_overflow      <= 1'b0;
      o_underflow_cnt <= '0;
    end else begin
      o_dac_valid <= pop;
      if (pop) begin
        o_dac_i <= head[DW-1:SAMPLE_W];
        o_dac_q <= head[SAMPLE_W-1:0];
      end else if (zero_out) begin
        o_dac_i <= '0;
        o_dac_q <= '0;
      end
      if (drop) o_overflow <= 1'b1;
      if (underflow && o_underflow_cnt != UNDERFLOW_MAX)
        o_underflow_cnt <= o_underflow_cnt + 16'd1;
    end
  end

  assign o_level = level;
  assign o_state = state;

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Scoreboard bench: a queue-level model predicts status and emissions,
// a negedge monitor compares the DUT against it.
module tb_dac_sample_feeder;
  import dac_feeder_pkg::*;

  localparam int DEPTH   = 64;
  localparam int PREFILL = 32;
  localparam int DIVIDER = 4;
  localparam int SW      = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          vld;
  logic [31:0]   din;
  logic [SW-1:0] o_dac_i;
  logic [SW-1:0] o_dac_q;
  logic          o_dac_valid;
  logic [6:0]    o_level;
  logic [1:0]    o_state;
  logic          o_overflow;
  logic [15:0]   o_underflow_cnt;

  dac_sample_feeder #(
    .DEPTH    (DEPTH),
    .PREFILL  (PREFILL),
    .DIVIDER  (DIVIDER),
    .SAMPLE_W (SW)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_enable        (en),
    .i_data          (din),
    .i_valid         (vld),
    .o_dac_i         (o_dac_i),
    .o_dac_q         (o_dac_q),
    .o_dac_valid     (o_dac_valid),
    .o_level         (o_level),
    .o_state         (o_state),
    .o_overflow      (o_overflow),
    .o_underflow_cnt (o_underflow_cnt)
  );

  always #5 clk = ~clk;

  iq_sample_t    m_q[$];
  iq_sample_t    exp_q[$];
  int            m_st;
  int            m_cnt;
  int            m_unf;
  bit            m_ovf;
  bit            m_dv;
  logic [SW-1:0] m_di;
  logic [SW-1:0] m_dq;
  bit            started;
  int            n_tests;
  int            n_fail;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: occupancy is the queue size; states follow the rules directly.
  always @(posedge clk) begin : model
    iq_sample_t s;
    bit         tick;
    int         nst;
    if (rst) begin
      m_q.delete();
      m_st = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
      m_di = 0; m_dq = 0; m_dv = 0;
      started = 1;
    end else begin
      tick  = (m_cnt == DIVIDER - 1);
      m_cnt = (m_cnt + 1) % DIVIDER;
      m_dv  = 0;
      if (!en) begin
        m_q.delete(); m_st = 0; m_di = 0; m_dq = 0;
      end else if (m_st == 0) begin
        m_q.delete(); m_st = 1; m_di = 0; m_dq = 0;
      end else begin
        nst = m_st;
        if (m_st == 1 && m_q.size() >= PREFILL) nst = 2;
        if (m_st == 2 && tick) begin
          if (m_q.size() > 0) begin
            s = m_q.pop_front();
            m_di = s.i; m_dq = s.q; m_dv = 1;
            exp_q.push_back(s);
          end else begin
            m_di = 0; m_dq = 0;
            if (m_unf < 65535) m_unf++;
            nst = 1;
          end
        end
        if (vld) begin
          if (m_q.size() < DEPTH) m_q.push_back(iq_sample_t'(din));
          else m_ovf = 1;
        end
        m_st = nst;
      end
    end
  end

  always @(negedge clk) begin : monitor
    iq_sample_t e;
    if (started) begin
      chk("dac_valid", 64'(o_dac_valid), 64'(m_dv));
      chk("state", 64'(o_state), 64'(m_st));
      chk("level", 64'(o_level), 64'(m_q.size()));
      chk("overflow", 64'(o_overflow), 64'(m_ovf));
      chk("underflow_cnt", 64'(o_underflow_cnt), 64'(m_unf));
      chk("dac_i", 64'(o_dac_i), 64'(m_di));
      chk("dac_q", 64'(o_dac_q), 64'(m_dq));
      if (o_dac_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: strobe with I=%0d but none expected",
                   o_dac_i);
        end else begin
          e = exp_q.pop_front();
          chk("sb_i", 64'(o_dac_i), 64'(e.i));
          chk("sb_q", 64'(o_dac_q), 64'(e.q));
        end
      end
    end
  end

  task automatic wait_run_level(input int lvl, input string name);
    int k;
    for (k = 0; k < 600; k++) begin
      if (m_st == 2 && m_q.size() == lvl) break;
      @(negedge clk);
    end
    chk(name, 64'(o_level), 64'(lvl));
  endtask

  initial begin
    logic [15:0] n16;
    int          sv_unf;
    bit          sv_ovf;
    bit          full_tick;
    int          full_ticks;
    rst = 1'b1; en = 1'b0; vld = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_state", 64'(o_state), 64'(0));
    chk("rst_level", 64'(o_level), 64'(0));
    chk("rst_valid", 64'(o_dac_valid), 64'(0));
    chk("rst_unf", 64'(o_underflow_cnt), 64'(0));

    // Prefill with I=n, Q=-n then start.
    en = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 32; n++) begin
      n16 = 16'(n);
      vld = 1'b1;
      din = {n16, 16'(-n16)};
      @(negedge clk);
    end
    vld = 1'b0;
    chk("t1_prefill", 64'(o_state), 64'(1));
    chk("t1_level", 64'(o_level), 64'(32));
    @(negedge clk);
    chk("t1_run", 64'(o_state), 64'(2));

    // Drain to underflow, then refill at a random rate.
    for (int k = 0; k < 400 && m_unf < 1; k++) @(negedge clk);
    chk("t2_unf", 64'(o_underflow_cnt), 64'(1));
    chk("t2_state", 64'(o_state), 64'(1));
    chk("t2_dac_i", 64'(o_dac_i), 64'(0));
    for (int k = 0; k < 300; k++) begin
      vld = ($urandom_range(0, 2) == 0);
      din = $urandom;
      @(negedge clk);
    end
    vld = 1'b0;

    // Enable drop at level 20 in RUN.
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      vld = 1'b1;
      din = $urandom;
      @(negedge clk);
    end
    vld = 1'b0;
    wait_run_level(20, "t5_level20");
    sv_unf = m_unf;
    sv_ovf = m_ovf;
    en = 1'b0;
    vld = 1'b1;
    din = $urandom;
    @(negedge clk);
    chk("t5_state", 64'(o_state), 64'(0));
    chk("t5_level", 64'(o_level), 64'(0));
    chk("t5_dac_i", 64'(o_dac_i), 64'(0));
    chk("t5_dac_q", 64'(o_dac_q), 64'(0));
    chk("t5_unf", 64'(o_underflow_cnt), 64'(sv_unf));
    chk("t5_ovf", 64'(o_overflow), 64'(sv_ovf));
    for (int k = 0; k < 4; k++) begin
      din = $urandom;
      @(negedge clk);
      chk("t5_ignored", 64'(o_level), 64'(0));
    end
    vld = 1'b0;
    en = 1'b1;

    // Overflow: continuous writes from reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 100; k++) begin
      vld = 1'b1;
      din = $urandom;
      @(negedge clk);
    end
    vld = 1'b0;
    chk("t3_ovf", 64'(o_overflow), 64'(1));
    chk("t3_level", 64'(o_level), 64'(DEPTH));

    // Reset mid-RUN with level 40 and overflow set.
    wait_run_level(40, "t6_level40");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_state", 64'(o_state), 64'(0));
    chk("t6_level", 64'(o_level), 64'(0));
    chk("t6_ovf", 64'(o_overflow), 64'(0));
    chk("t6_valid", 64'(o_dac_valid), 64'(0));
    chk("t6_dac_i", 64'(o_dac_i), 64'(0));

    // Hold full in RUN, pushing only on tick cycles.
    full_ticks = 0;
    for (int k = 0; k < 800 && full_ticks < 6; k++) begin
      full_tick = (m_st == 2 && m_cnt == DIVIDER - 1
                   && m_q.size() == DEPTH);
      vld = (m_st != 0) && (m_q.size() < DEPTH || full_tick);
      din = $urandom;
      @(negedge clk);
      if (full_tick) begin
        full_ticks++;
        chk("t4_level", 64'(o_level), 64'(DEPTH));
        chk("t4_ovf", 64'(o_overflow), 64'(0));
      end
    end
    vld = 1'b0;
    chk("t4_reached", 64'(full_ticks), 64'(6));

    // Random traffic with occasional disables and resets.
    for (int seg = 0; seg < 6; seg++) begin
      int rate;
      rate = $urandom_range(10, 90);
      for (int k = 0; k < 250; k++) begin
        rst = ($urandom_range(0, 499) == 0);
        en  = ($urandom_range(0, 99) != 0);
        vld = ($urandom_range(0, 99) < rate);
        din = $urandom;
        @(negedge clk);
      end
    end
    rst = 1'b0;
    en  = 1'b1;
    vld = 1'b0;
    repeat (10) @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
